tff_sync_counter: RTL and testbench
===================================

// Module: tff_sync_counter
// PURPOSE
//  Synchronous up/down modulo counter built as a chain of T-type toggle stages.
//  Each stage sits downstream of a per-bit toggle-enable generator and consumes its T input.
//  Provides load, terminal-count and wrap indication.
//  Used as the counting/divider stage fed by the single-bit toggle flip-flops in Flip_flop_designs.
// PARAMETERS
//  WIDTH    4    counter width in bits (>=2)
//  MOD_MAX  15   highest count value before wrap (1 .. 2**WIDTH-1)
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      synchronous, active-high reset
//  en        in   1      count enable; one step per clk edge when high
//  up        in   1      direction: 1 = increment, 0 = decrement
//  load      in   1      load load_val on next edge (priority over en)
//  load_val  in   WIDTH  value to load; values > MOD_MAX clamp to MOD_MAX
//  q         out  WIDTH  registered count value
//  t_vec     out  WIDTH  per-bit toggle enables currently applied (combinational)
//  tc        out  1      terminal count, combinational: en & ~load & at boundary
//  wrap      out  1      registered one-cycle pulse, the cycle after a wrap occurred
// BEHAVIOUR
//  - One clock; reset is synchronous, active-high. On reset: q=0, wrap=0. tc and t_vec follow from q=0.
//  - Priority per edge: reset > load > en > hold.
//  - Each bit i is a T stage with q[i] <= q[i] ^ t_vec[i].
//  - Normal up step (q != MOD_MAX): t_vec[i] = en & (&q[i-1:0]); t_vec[0] = en.
//  - Normal down step (q != 0): t_vec[i] = en & ~(|q[i-1:0]); t_vec[0] = en.
//  - Boundary up: q == MOD_MAX with en -> next q = 0; t_vec = q (toggles all set bits).
//  - Boundary down: q == 0 with en -> next q = MOD_MAX; t_vec = MOD_MAX.
//  - tc = en & ~load & ((up & q==MOD_MAX) | (~up & q==0)).
//  - wrap <= tc (registered); high exactly one cycle after each wrap edge.
//  - load: q <= min(load_val, MOD_MAX); wrap <= 0; t_vec = q ^ loaded value. Single-cycle latency.
//  - en low: q holds, t_vec = 0, tc = 0; wrap drops to 0 next edge.
//  - up may change any cycle; the new direction takes effect at the same edge.
//    The count never leaves 0..MOD_MAX.
//  - Reset mid-count: q = 0 on that edge regardless of en/load; wrap cleared.
//  - No state beyond q and wrap; no multi-cycle latency anywhere.
// TESTING
//  1 Reset: reset=1 for 2 edges with en=1, load=1, load_val=9 -> q=0, wrap=0 after each edge.
//  2 Up wrap (defaults): en=1, up=1 from 0 for 16 edges -> q = 1..15, 0.
//    tc=1 only while q=15; wrap=1 only in the cycle q=0 follows 15.
//  3 Down wrap: MOD_MAX=9, q=0, en=1, up=0 -> next q=9, tc=1 at q=0.
//    3 more edges -> 8, 7, 6.
//  4 Load priority and clamp: MOD_MAX=9, load=1, en=1, load_val=12 -> q=9, tc=0 that cycle.
//    load_val=5 -> q=5.
//  5 Hold/direction change: q=6, en=0 for 3 edges -> q=6, t_vec=0.
//    en=1, up toggled each cycle -> 7, 6, 7, 6.
//  6 Toggle check: q=4'b0111, up=1, en=1 -> t_vec=4'b1111, next q=4'b1000.
//    q=4'b1000, up=0 -> t_vec=4'b1111, next q=4'b0111.

Source files
------------

// File: rtl/tff_sync_counter.sv
// Up/down modulo counter built from T-type stages: a per-bit toggle-enable
// generator drives t_vec, and every bit simply flips when its enable is set.
module tff_sync_counter #(
  parameter int WIDTH   = 4,
  parameter int MOD_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD_MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] tVec;
  logic [WIDTH-1:0] loadClamped;
  logic             atMax, atZero, termCount, chain;

  // Toggle-enable generator. A load toggles exactly the bits that differ from
  // the clamped target. At a boundary the wrap value is reached by toggling.
  // Otherwise a ripple chain toggles bit i when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    atMax       = (count_q == MaxVal);
    atZero      = (count_q == '0);
    loadClamped = (load_val > MaxVal) ? MaxVal : load_val;
    termCount   = en & ~load & ((up & atMax) | (~up & atZero));
    tVec        = '0;
    chain       = 1'b1;
    if (load) begin
      tVec = count_q ^ loadClamped;
    end else if (en) begin
      if (up && atMax) begin
        tVec = count_q;
      end else if (!up && atZero) begin
        tVec = MaxVal;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          tVec[i] = chain;
          chain   = chain & (up ? count_q[i] : ~count_q[i]);
        end
      end
    end
    count_d = count_q ^ tVec;
    wrap_d  = termCount;
  end

  // T stages plus the registered wrap pulse; load and idle cycles force
  // termCount low, so wrap clears on those edges automatically.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q     = count_q;
  assign t_vec = tVec;
  assign tc    = termCount;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_tff_sync_counter.sv
// Scoreboard bench for tff_sync_counter: a default (mod 16) and a MOD_MAX=9
// instance share the stimulus and are compared against an arithmetic model.
module tb_tff_sync_counter;

  logic       clk;
  logic       reset, en, up, load;
  logic [3:0] loadVal;
  logic [3:0] q16, tVec16, q9, tVec9;
  logic       tc16, wrap16, tc9, wrap9;

  typedef struct {
    logic [3:0] q16;
    logic       w16;
    logic [3:0] q9;
    logic       w9;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [3:0] mq16, mq9;
  int         total, bad;

  tff_sync_counter dut16 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(loadVal),
    .q(q16), .t_vec(tVec16), .tc(tc16), .wrap(wrap16)
  );

  tff_sync_counter #(.WIDTH(4), .MOD_MAX(9)) dut9 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(loadVal),
    .q(q9), .t_vec(tVec9), .tc(tc9), .wrap(wrap9)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference behaviour as plain modular arithmetic: returns {wrap, q}.
  function automatic logic [4:0] modelNext(input logic [3:0] cq, input logic [3:0] m,
      input logic r, input logic el, input logic u, input logic l, input logic [3:0] v);
    if (r) return 5'd0;
    if (l) return {1'b0, (v > m) ? m : v};
    if (!el) return {1'b0, cq};
    if (u) return (cq == m) ? {1'b1, 4'd0} : {1'b0, cq + 4'd1};
    return (cq == 4'd0) ? {1'b1, m} : {1'b0, cq - 4'd1};
  endfunction

  function automatic logic [3:0] modelTvec(input logic [3:0] cq, input logic [3:0] m,
      input logic el, input logic u, input logic l, input logic [3:0] v);
    logic [4:0] n;
    if (!l && !el) return 4'd0;
    n = modelNext(cq, m, 1'b0, el, u, l, v);
    return cq ^ n[3:0];
  endfunction

  function automatic logic modelTc(input logic [3:0] cq, input logic [3:0] m,
      input logic el, input logic u, input logic l);
    return el & ~l & ((u & (cq == m)) | (~u & (cq == 4'd0)));
  endfunction

  task automatic setInputs(input logic r, input logic el, input logic u, input logic l,
      input logic [3:0] v);
    reset = r; en = el; up = u; load = l; loadVal = v;
    #1;
  endtask

  // Push the expected post-edge state, then advance one clock.
  task automatic applyStimulus();
    logic [4:0] n16, n9;
    exp_t x;
    n16 = modelNext(mq16, 4'd15, reset, en, up, load, loadVal);
    n9  = modelNext(mq9, 4'd9, reset, en, up, load, loadVal);
    x.q16 = n16[3:0]; x.w16 = n16[4]; x.q9 = n9[3:0]; x.w9 = n9[4];
    sb.push_back(x);
    @(posedge clk);
    #1;
    mq16 = n16[3:0];
    mq9  = n9[3:0];
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      setInputs(1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
      applyStimulus();
      e = sb.pop_front();
      total++; if (q16 !== e.q16 || q16 !== 4'd0) begin bad++; $display("FAIL reset q16: got %0d want 0", q16); end
      total++; if (wrap16 !== e.w16 || wrap16 !== 1'b0) begin bad++; $display("FAIL reset wrap16: got %b want 0", wrap16); end
      total++; if (q9 !== e.q9 || q9 !== 4'd0) begin bad++; $display("FAIL reset q9: got %0d want 0", q9); end
      total++; if (wrap9 !== e.w9) begin bad++; $display("FAIL reset wrap9: got %b want %b", wrap9, e.w9); end
    end
  endtask

  task automatic test_up_wrap();
    for (int i = 0; i < 16; i++) begin
      setInputs(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      total++; if (tc16 !== (mq16 == 4'd15)) begin bad++; $display("FAIL up_wrap tc16 at q=%0d: got %b", mq16, tc16); end
      total++; if (tVec16 !== modelTvec(mq16, 4'd15, en, up, load, loadVal)) begin
        bad++; $display("FAIL up_wrap t_vec16 at q=%0d: got %b want %b", mq16, tVec16, modelTvec(mq16, 4'd15, en, up, load, loadVal)); end
      applyStimulus();
      e = sb.pop_front();
      total++; if (q16 !== e.q16 || q16 !== 4'((i + 1) % 16)) begin bad++; $display("FAIL up_wrap q16 step %0d: got %0d want %0d", i, q16, e.q16); end
      total++; if (wrap16 !== (i == 15)) begin bad++; $display("FAIL up_wrap wrap16 step %0d: got %b want %b", i, wrap16, i == 15); end
      total++; if (q9 !== e.q9) begin bad++; $display("FAIL up_wrap q9 step %0d: got %0d want %0d", i, q9, e.q9); end
      total++; if (wrap9 !== e.w9) begin bad++; $display("FAIL up_wrap wrap9 step %0d: got %b want %b", i, wrap9, e.w9); end
    end
  endtask

  task automatic test_down_wrap();
    int want[4] = '{9, 8, 7, 6};
    setInputs(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus();
    e = sb.pop_front();
    total++; if (q9 !== 4'd0) begin bad++; $display("FAIL down_wrap reset q9: got %0d want 0", q9); end
    for (int i = 0; i < 4; i++) begin
      setInputs(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      total++; if (tc9 !== (i == 0)) begin bad++; $display("FAIL down_wrap tc9 step %0d: got %b want %b", i, tc9, i == 0); end
      applyStimulus();
      e = sb.pop_front();
      total++; if (q9 !== e.q9 || q9 !== 4'(want[i])) begin bad++; $display("FAIL down_wrap q9 step %0d: got %0d want %0d", i, q9, want[i]); end
      total++; if (wrap9 !== (i == 0)) begin bad++; $display("FAIL down_wrap wrap9 step %0d: got %b want %b", i, wrap9, i == 0); end
      total++; if (q16 !== e.q16) begin bad++; $display("FAIL down_wrap q16 step %0d: got %0d want %0d", i, q16, e.q16); end
    end
  endtask

  task automatic test_load();
    setInputs(1'b0, 1'b1, 1'b1, 1'b1, 4'd12);
    total++; if (tc9 !== 1'b0 || tc16 !== 1'b0) begin bad++; $display("FAIL load tc: got %b/%b want 0/0", tc16, tc9); end
    applyStimulus();
    e = sb.pop_front();
    total++; if (q9 !== e.q9 || q9 !== 4'd9) begin bad++; $display("FAIL load clamp q9: got %0d want 9", q9); end
    total++; if (q16 !== 4'd12) begin bad++; $display("FAIL load q16: got %0d want 12", q16); end
    total++; if (wrap9 !== 1'b0) begin bad++; $display("FAIL load wrap9: got %b want 0", wrap9); end
    setInputs(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
    applyStimulus();
    e = sb.pop_front();
    total++; if (q9 !== 4'd5 || q16 !== 4'd5) begin bad++; $display("FAIL load q=5: got %0d/%0d want 5/5", q16, q9); end
  endtask

  task automatic test_hold_dir();
    logic [3:0] want[4] = '{4'd7, 4'd6, 4'd7, 4'd6};
    setInputs(1'b0, 1'b0, 1'b1, 1'b1, 4'd6);
    applyStimulus();
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      setInputs(1'b0, 1'b0, i[0], 1'b0, 4'd0);
      total++; if (tVec9 !== 4'd0 || tc9 !== 1'b0) begin bad++; $display("FAIL hold t_vec9/tc9: got %b/%b want 0000/0", tVec9, tc9); end
      applyStimulus();
      e = sb.pop_front();
      total++; if (q9 !== 4'd6 || q9 !== e.q9) begin bad++; $display("FAIL hold q9 step %0d: got %0d want 6", i, q9); end
      total++; if (wrap9 !== 1'b0) begin bad++; $display("FAIL hold wrap9: got %b want 0", wrap9); end
    end
    for (int i = 0; i < 4; i++) begin
      setInputs(1'b0, 1'b1, ~i[0], 1'b0, 4'd0);
      applyStimulus();
      e = sb.pop_front();
      total++; if (q9 !== want[i] || q9 !== e.q9) begin bad++; $display("FAIL direction q9 step %0d: got %0d want %0d", i, q9, want[i]); end
    end
  endtask

  task automatic test_toggle();
    setInputs(1'b0, 1'b0, 1'b1, 1'b1, 4'b0111);
    applyStimulus();
    e = sb.pop_front();
    setInputs(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    total++; if (tVec16 !== 4'b1111 || tVec9 !== 4'b1111) begin bad++; $display("FAIL toggle_up t_vec: got %b/%b want 1111", tVec16, tVec9); end
    applyStimulus();
    e = sb.pop_front();
    total++; if (q16 !== 4'b1000 || q9 !== 4'b1000) begin bad++; $display("FAIL toggle_up q: got %b/%b want 1000", q16, q9); end
    setInputs(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    total++; if (tVec16 !== 4'b1111 || tVec9 !== 4'b1111) begin bad++; $display("FAIL toggle_down t_vec: got %b/%b want 1111", tVec16, tVec9); end
    applyStimulus();
    e = sb.pop_front();
    total++; if (q16 !== 4'b0111 || q9 !== 4'b0111) begin bad++; $display("FAIL toggle_down q: got %b/%b want 0111", q16, q9); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      setInputs($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                $urandom_range(0, 7) == 0, 4'($urandom));
      total++; if (tc16 !== modelTc(mq16, 4'd15, en, up, load) || tc9 !== modelTc(mq9, 4'd9, en, up, load)) begin
        bad++; $display("FAIL random tc step %0d: got %b/%b", i, tc16, tc9); end
      total++; if (tVec16 !== modelTvec(mq16, 4'd15, en, up, load, loadVal) || tVec9 !== modelTvec(mq9, 4'd9, en, up, load, loadVal)) begin
        bad++; $display("FAIL random t_vec step %0d: got %b/%b want %b/%b", i, tVec16, tVec9,
                        modelTvec(mq16, 4'd15, en, up, load, loadVal), modelTvec(mq9, 4'd9, en, up, load, loadVal)); end
      applyStimulus();
      e = sb.pop_front();
      total++; if (q16 !== e.q16 || wrap16 !== e.w16) begin bad++; $display("FAIL random dut16 step %0d: got q=%0d w=%b want q=%0d w=%b", i, q16, wrap16, e.q16, e.w16); end
      total++; if (q9 !== e.q9 || wrap9 !== e.w9) begin bad++; $display("FAIL random dut9 step %0d: got q=%0d w=%b want q=%0d w=%b", i, q9, wrap9, e.q9, e.w9); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    mq16 = 4'd0; mq9 = 4'd0;
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; loadVal = 4'd0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_hold_dir();
    test_toggle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
